// File: rtl/tmu_pixout.sv
// TMU output stage: write-combines 16-bit pixels into one 32-byte FML line
// buffer and drains it as a 4-beat write burst on line change or flush.
module tmu_pixout #(
  parameter int fml_depth = 26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 flush,
  output logic                 busy,
  input  logic                 pipe_stb_i,
  output logic                 pipe_ack_o,
  input  logic [15:0]          src_pixel,
  input  logic [fml_depth-2:0] dst_addr1,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_ack,
  output logic [7:0]           fml_sel,
  output logic [63:0]          fml_do,
  output logic                 inc_writes
);

  localparam int TAG_W = fml_depth - 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    BEAT1 = 3'd2,
    BEAT2 = 3'd3,
    BEAT3 = 3'd4,
    BEAT4 = 3'd5
  } state_t;

  // Big-endian lane placement: lane 0 occupies the top half-word of a beat.
  function automatic logic [7:0] lane_sel(input logic [1:0] lane);
    lane_sel = 8'hC0 >> {lane, 1'b0};
  endfunction

  function automatic logic [63:0] lane_bits(input logic [15:0] pix, input logic [1:0] lane);
    lane_bits = {pix, 48'h0000_0000_0000} >> {lane, 4'h0};
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                valid_r;
  logic                valid_nxt_s;
  logic                pending_r;
  logic                pending_nxt_s;
  logic                burst_flush_r;
  logic                rdy_r;
  logic [TAG_W-1:0]    tag_r;
  logic [31:0]         mask_r;
  logic [3:0][63:0]    data_r;

  logic [fml_depth-1:0] fml_adr_r;
  logic                 fml_stb_r;
  logic                 fml_we_r;
  logic [7:0]           fml_sel_r;
  logic [63:0]          fml_do_r;
  logic                 inc_writes_r;
  logic                 busy_r;

  logic [TAG_W-1:0]    pix_tag_s;
  logic [1:0]          pix_beat_s;
  logic [1:0]          pix_lane_s;
  logic                hit_s;
  logic                ack_s;
  logic                accept_s;

  assign pix_tag_s  = dst_addr1[fml_depth-2:4];
  assign pix_beat_s = dst_addr1[3:2];
  assign pix_lane_s = dst_addr1[1:0];
  assign hit_s      = (tag_r == pix_tag_s);

  // rdy_r keeps the ack low while in reset and for the first edge after it.
  assign ack_s    = rdy_r & (state_r == IDLE) & ~pending_r & ~flush & (~valid_r | hit_s);
  assign accept_s = pipe_stb_i & ack_s;

  // Next-state, buffer-valid and flush-pending decode.
  always_comb begin
    state_nxt_s   = state_r;
    valid_nxt_s   = valid_r;
    pending_nxt_s = pending_r;
    case (state_r)
      IDLE: begin
        if (pending_r & valid_r) begin
          state_nxt_s = WRITE;
        end else if (pending_r) begin
          pending_nxt_s = 1'b0;
        end else if (pipe_stb_i & valid_r & ~hit_s) begin
          state_nxt_s = WRITE;
        end else if (accept_s) begin
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (fml_ack) begin
          state_nxt_s = BEAT1;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      BEAT1: state_nxt_s = BEAT2;
      BEAT2: state_nxt_s = BEAT3;
      BEAT3: state_nxt_s = BEAT4;
      BEAT4: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
        if (burst_flush_r) begin
          pending_nxt_s = 1'b0;
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        valid_nxt_s   = 1'b0;
        pending_nxt_s = 1'b0;
      end
    endcase
    // A new flush request always wins over any clear in the same cycle.
    if (flush) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Control state, tag and burst address registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= IDLE;
      valid_r       <= 1'b0;
      pending_r     <= 1'b0;
      burst_flush_r <= 1'b0;
      rdy_r         <= 1'b0;
      tag_r         <= '0;
      fml_adr_r     <= '0;
    end else begin
      state_r   <= state_nxt_s;
      valid_r   <= valid_nxt_s;
      pending_r <= pending_nxt_s;
      rdy_r     <= 1'b1;
      if (accept_s) begin
        tag_r <= pix_tag_s;
      end
      if ((state_r == IDLE) && (state_nxt_s == WRITE)) begin
        burst_flush_r <= pending_r;
        fml_adr_r     <= {tag_r, 5'b0_0000};
      end
    end
  end

  // Line buffer data and byte mask; the mask empties once the burst drains.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_r <= '0;
      mask_r <= 32'h0000_0000;
    end else if (accept_s) begin
      data_r[pix_beat_s] <= (data_r[pix_beat_s] & ~lane_bits(16'hFFFF, pix_lane_s))
                            | lane_bits(src_pixel, pix_lane_s);
      mask_r <= mask_r | ({24'h00_0000, lane_sel(pix_lane_s)} << {pix_beat_s, 3'b000});
    end else if (state_r == BEAT4) begin
      mask_r <= 32'h0000_0000;
    end
  end

  // FML outputs registered from the next state so beats line up with it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fml_stb_r    <= 1'b0;
      fml_we_r     <= 1'b0;
      fml_sel_r    <= 8'h00;
      fml_do_r     <= 64'h0;
      inc_writes_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      fml_stb_r    <= (state_nxt_s == WRITE);
      fml_we_r     <= (state_nxt_s == WRITE);
      inc_writes_r <= (state_r == WRITE) & fml_ack;
      busy_r       <= valid_nxt_s | pending_nxt_s | (state_nxt_s != IDLE);
      case (state_nxt_s)
        BEAT1: begin
          fml_do_r  <= data_r[0];
          fml_sel_r <= mask_r[7:0];
        end
        BEAT2: begin
          fml_do_r  <= data_r[1];
          fml_sel_r <= mask_r[15:8];
        end
        BEAT3: begin
          fml_do_r  <= data_r[2];
          fml_sel_r <= mask_r[23:16];
        end
        BEAT4: begin
          fml_do_r  <= data_r[3];
          fml_sel_r <= mask_r[31:24];
        end
        default: begin
          fml_do_r  <= 64'h0;
          fml_sel_r <= 8'h00;
        end
      endcase
    end
  end

  assign pipe_ack_o = ack_s;
  assign fml_adr    = fml_adr_r;
  assign fml_stb    = fml_stb_r;
  assign fml_we     = fml_we_r;
  assign fml_sel    = fml_sel_r;
  assign fml_do     = fml_do_r;
  assign inc_writes = inc_writes_r;
  assign busy       = busy_r;

endmodule
